iob_ibex2axi_ot: RTL

Bridge from one Ibex LSU/instruction-fetch port to an AXI4 manager, with up to MAX_OT outstanding transactions. AW and W are handshaked independently. Responses are returned to Ibex strictly in request order, even when the AXI subordinate could return R and B in a different order. Sits between the Ibex core and the SoC AXI interconnect, one instance per Ibex memory port.

---
 rtl/iob_ibex2axi_pkg.sv | 18 +
 rtl/iob_ibex2axi_ord_fifo.sv | 53 +++++
 rtl/iob_ibex2axi_ot.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/iob_ibex2axi_pkg.sv
// Shared AXI encodings and the response-mux select type for the Ibex-to-AXI bridge.
package iob_ibex2axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

  // Which AXI response channel feeds the Ibex response register.
  typedef enum logic {
    RSP_SEL_R = 1'b0,
    RSP_SEL_B = 1'b1
  } rsp_sel_t;

endpackage

// File: rtl/iob_ibex2axi_ord_fifo.sv
// Ordering FIFO: remembers the type (read/write) of each granted transaction
// so responses are handed back to Ibex in request order.
module iob_ibex2axi_ord_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             cke,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             din,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Entry storage; contents need no reset since count qualifies them.
  always_ff @(posedge clk) begin
    if (cke && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (cke) begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/iob_ibex2axi_ot.sv
// Ibex memory port to AXI4 manager bridge with up to MAX_OT outstanding
// single-beat transactions; responses return to Ibex in request order.
module iob_ibex2axi_ot
  import iob_ibex2axi_pkg::*;
#(
  parameter int unsigned AXI_ID_W    = 1,
  parameter int unsigned AXI_ID      = 0,
  parameter int unsigned AXI_ADDR_W  = 32,
  parameter int unsigned AXI_DATA_W  = 32,
  parameter int unsigned AXI_LEN_W   = 8,
  parameter int unsigned IBEX_ADDR_W = 32,
  parameter int unsigned MAX_OT      = 4,
  parameter logic [2:0]  AXI_PROT    = 3'b000,
  parameter logic [3:0]  AXI_CACHE   = 4'b0011
) (
  input  logic                   clk_i,
  input  logic                   cke_i,
  input  logic                   rst_ni,
  input  logic                   ibex_req_i,
  input  logic                   ibex_we_i,
  input  logic [3:0]             ibex_be_i,
  input  logic [IBEX_ADDR_W-1:0] ibex_addr_i,
  input  logic [31:0]            ibex_wdata_i,
  output logic                   ibex_gnt_o,
  output logic                   ibex_rvalid_o,
  output logic [31:0]            ibex_rdata_o,
  output logic                   ibex_err_o,
  output logic                   awvalid_o,
  input  logic                   awready_i,
  output logic [AXI_ADDR_W-1:0]  awaddr_o,
  output logic [AXI_ID_W-1:0]    awid_o,
  output logic [AXI_LEN_W-1:0]   awlen_o,
  output logic [2:0]             awsize_o,
  output logic [1:0]             awburst_o,
  output logic                   awlock_o,
  output logic [3:0]             awcache_o,
  output logic [2:0]             awprot_o,
  output logic [3:0]             awqos_o,
  output logic                   wvalid_o,
  input  logic                   wready_i,
  output logic [AXI_DATA_W-1:0]  wdata_o,
  output logic [3:0]             wstrb_o,
  output logic                   wlast_o,
  input  logic                   bvalid_i,
  input  logic [1:0]             bresp_i,
  input  logic [AXI_ID_W-1:0]    bid_i,
  output logic                   bready_o,
  output logic                   arvalid_o,
  input  logic                   arready_i,
  output logic [AXI_ADDR_W-1:0]  araddr_o,
  output logic [AXI_ID_W-1:0]    arid_o,
  output logic [AXI_LEN_W-1:0]   arlen_o,
  output logic [2:0]             arsize_o,
  output logic [1:0]             arburst_o,
  output logic                   arlock_o,
  output logic [3:0]             arcache_o,
  output logic [2:0]             arprot_o,
  output logic [3:0]             arqos_o,
  input  logic                   rvalid_i,
  input  logic [AXI_DATA_W-1:0]  rdata_i,
  input  logic [1:0]             rresp_i,
  input  logic [AXI_ID_W-1:0]    rid_i,
  input  logic                   rlast_i,
  output logic                   rready_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OT) + 1;

  logic             aw_done;
  logic             w_done;
  logic             req_ok;
  logic             gnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_is_write;
  logic [CNT_W-1:0] fifo_count;
  logic             r_hs;
  logic             b_hs;
  logic             pop;
  logic [AXI_ADDR_W-1:0] axi_addr;
  rsp_sel_t         rsp_sel;
  logic             unused;

  // Full comes from the registered count, so a pop in this cycle cannot admit.
  assign req_ok    = cke_i & ibex_req_i & ~fifo_full;
  assign arvalid_o = req_ok & ~ibex_we_i;
  assign awvalid_o = req_ok & ibex_we_i & ~aw_done;
  assign wvalid_o  = req_ok & ibex_we_i & ~w_done;
  assign gnt       = ibex_we_i ? (req_ok & (aw_done | awready_i) & (w_done | wready_i))
                               : (arvalid_o & arready_i);
  assign ibex_gnt_o = gnt;

  // Only the channel matching the oldest outstanding transaction is accepted.
  assign rready_o = cke_i & ~fifo_empty & ~head_is_write;
  assign bready_o = cke_i & ~fifo_empty & head_is_write;
  assign r_hs     = rvalid_i & rready_o;
  assign b_hs     = bvalid_i & bready_o;
  assign pop      = r_hs | b_hs;
  assign rsp_sel  = head_is_write ? RSP_SEL_B : RSP_SEL_R;

  assign axi_addr = AXI_ADDR_W'({ibex_addr_i[IBEX_ADDR_W-1:2], 2'b00});
  assign awaddr_o = axi_addr;
  assign araddr_o = axi_addr;
  assign wdata_o  = AXI_DATA_W'(ibex_wdata_i);
  assign wstrb_o  = ibex_be_i;
  assign wlast_o  = 1'b1;

  assign awid_o    = AXI_ID_W'(AXI_ID);
  assign awlen_o   = '0;
  assign awsize_o  = AXI_SIZE_4B;
  assign awburst_o = AXI_BURST_INCR;
  assign awlock_o  = 1'b0;
  assign awcache_o = AXI_CACHE;
  assign awprot_o  = AXI_PROT;
  assign awqos_o   = '0;
  assign arid_o    = AXI_ID_W'(AXI_ID);
  assign arlen_o   = '0;
  assign arsize_o  = AXI_SIZE_4B;
  assign arburst_o = AXI_BURST_INCR;
  assign arlock_o  = 1'b0;
  assign arcache_o = AXI_CACHE;
  assign arprot_o  = AXI_PROT;
  assign arqos_o   = '0;

  assign unused = ^{bid_i, rid_i, rlast_i, ibex_addr_i[1:0], fifo_count};

  iob_ibex2axi_ord_fifo #(
    .DEPTH(MAX_OT)
  ) u_ord_fifo (
    .clk   (clk_i),
    .cke   (cke_i),
    .rst_n (rst_ni),
    .push  (gnt),
    .pop   (pop),
    .din   (ibex_we_i),
    .dout  (head_is_write),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Remember AW/W handshakes that completed before the write was granted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (cke_i) begin
      if (gnt) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (awvalid_o && awready_i) aw_done <= 1'b1;
        if (wvalid_o && wready_i)   w_done  <= 1'b1;
      end
    end
  end

  // Registered Ibex response, loaded from whichever channel popped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ibex_rvalid_o <= 1'b0;
      ibex_rdata_o  <= '0;
      ibex_err_o    <= 1'b0;
    end else if (cke_i) begin
      ibex_rvalid_o <= pop;
      if (pop) begin
        unique case (rsp_sel)
          RSP_SEL_R: begin
            ibex_rdata_o <= 32'(rdata_i);
            ibex_err_o   <= (rresp_i != AXI_RESP_OKAY);
          end
          RSP_SEL_B: begin
            ibex_rdata_o <= '0;
            ibex_err_o   <= (bresp_i != AXI_RESP_OKAY);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
